// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes big-endian 32-bit words to
// instruction memory and releases the core once the frame checksum matches.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  // Counters hold N = 2**ADDR_W without overflow.
  localparam int CW = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;
  localparam logic [CW-1:0] MAX_N = CW'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state, next_state;
  logic [7:0]      len_hi;
  logic [CW-1:0]   len, word_cnt;
  logic [1:0]      byte_idx;
  logic [23:0]     shreg;
  logic [7:0]      xsum;
  logic            xfer;
  logic [CW-1:0]   len_next;
  logic            last_word;

  always_comb begin
    next_state = state;
    xfer       = in_valid && in_ready;
    len_next   = {{(CW-16){1'b0}}, len_hi, in_data};
    last_word  = (byte_idx == 2'd3) && ((word_cnt + CW'(1)) == len);
    case (state)
      S_IDLE:   if (xfer) next_state = S_LEN_LO;
      S_LEN_LO: if (xfer) begin
        if (len_next > MAX_N)      next_state = S_ERR;
        else if (len_next == '0)   next_state = S_CSUM;
        else                       next_state = S_DATA;
      end
      S_DATA:   if (xfer && last_word) next_state = S_CSUM;
      S_CSUM:   if (xfer) next_state = (in_data == xsum) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:    if (start) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      len_hi    <= '0;
      len       <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      xsum      <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != S_DONE) && (next_state != S_ERR);
      done     <= (next_state == S_DONE);
      err      <= (next_state == S_ERR);
      cpu_rst  <= (next_state != S_DONE);
      mem_we   <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if (xfer && state != S_CSUM) xsum <= xsum ^ in_data;
      case (state)
        S_IDLE:   if (xfer) len_hi <= in_data;
        S_LEN_LO: if (xfer) begin
          len      <= len_next;
          word_cnt <= '0;
          byte_idx <= '0;
        end
        S_DATA:   if (xfer) begin
          byte_idx <= byte_idx + 2'd1;
          shreg    <= {shreg[15:0], in_data};
          if (byte_idx == 2'd3) begin
            mem_we    <= 1'b1;
            mem_wdata <= {shreg, in_data};
            word_cnt  <= word_cnt + CW'(1);
          end
        end
        S_DONE,
        S_ERR:    if (start) begin
          mem_addr <= '0;
          xsum     <= '0;
          len_hi   <= '0;
          len      <= '0;
          word_cnt <= '0;
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
